fifo_rd_stream: RTL and testbench

Read-side engine for the `synfifo` synchronous FIFO. It pulls words through the FIFO's `rd` / `rd_data` / `rd_data_vld` interface and presents them downstream as a valid/ready stream at one word per cycle. A 3-entry skid buffer absorbs the FIFO's 1-cycle read latency, so `fifo_rd` has no combinational dependence on `m_ready`. It sits between the FIFO's read port and any streaming consumer.

---
 rtl/fifo_rd_stream.sv | 84 ++++++++
 tb/tb_fifo_rd_stream.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side engine for synfifo: pulls words through the 1-cycle-latency read port
// and re-times them into a valid/ready stream through a 3-entry skid buffer.
module fifo_rd_stream #(
  parameter int DATA_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              flush,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_rd_data_vld,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic              err_unexp
);

  logic [DATA_W-1:0] buf_mem [3];
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [1:0]        buf_cnt;
  logic              inflight;
  logic              drop;
  logic [2:0]        credit_used;
  logic              pop;
  logic              capture;
  logic              discard;
  logic              unexp;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A read may only issue when a buffer slot is guaranteed for its return.
  assign credit_used = {1'b0, buf_cnt} + {2'b00, inflight};
  assign fifo_rd     = ~rst_n & en & ~fifo_empty & ~flush & (credit_used < 3'd3);

  assign m_valid = (buf_cnt != 2'd0);
  assign m_data  = buf_mem[rd_ptr];
  assign pop     = m_valid & m_ready;
  assign capture = fifo_rd_data_vld & inflight & ~drop;
  assign discard = fifo_rd_data_vld & drop;
  assign unexp   = fifo_rd_data_vld & ~inflight & ~drop;

  // A flush only arms drop for a return that has not yet shown up; a word
  // arriving in the flush cycle itself is already discarded by the clear.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) buf_mem[i] <= '0;
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      buf_cnt   <= 2'd0;
      inflight  <= 1'b0;
      drop      <= 1'b0;
      xfer_cnt  <= '0;
      err_unexp <= 1'b0;
    end else begin
      inflight <= fifo_rd;
      if (pop)     xfer_cnt  <= xfer_cnt + CNT_W'(1);
      if (unexp)   err_unexp <= 1'b1;
      if (capture) buf_mem[wr_ptr] <= fifo_rd_data;
      if (flush) begin
        wr_ptr  <= 2'd0;
        rd_ptr  <= 2'd0;
        buf_cnt <= 2'd0;
        drop    <= inflight & ~fifo_rd_data_vld;
      end else begin
        if (discard) drop   <= 1'b0;
        if (capture) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)     rd_ptr <= ptr_inc(rd_ptr);
        case ({capture, pop})
          2'b10:   buf_cnt <= buf_cnt + 2'd1;
          2'b01:   buf_cnt <= buf_cnt - 2'd1;
          default: buf_cnt <= buf_cnt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a behavioural FIFO feeds the read port and a
// monitor compares every delivered word against the queue of written words.
module tb_fifo_rd_stream;
  localparam int DATA_W = 5;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              flush;
  logic              fifo_empty;
  logic              fifo_rd;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_rd_data_vld;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [CNT_W-1:0]  xfer_cnt;
  logic              err_unexp;

  logic [DATA_W-1:0] fifo_q [$];
  logic [DATA_W-1:0] exp_q [$];
  logic              rd_pending = 1'b0;
  logic              inject = 1'b0;
  logic [DATA_W-1:0] inj_data = '0;
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic [31:0]       lcg = 32'd100;
  int total = 0;
  int bad = 0;
  int rd_count = 0;
  int hs_count = 0;
  int outstanding = 0;
  int exp_xfer = 0;

  fifo_rd_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .fifo_empty(fifo_empty),
    .fifo_rd(fifo_rd), .fifo_rd_data(fifo_rd_data), .fifo_rd_data_vld(fifo_rd_data_vld),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .xfer_cnt(xfer_cnt), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [DATA_W-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 300) begin
      tick();
      n++;
    end
    total++;
    if (exp_q.size() != 0 || m_valid) begin
      bad++;
      $display("[TB] FAIL %s_drain: %0d words pending, expected 0", name, exp_q.size());
    end
    tick();
  endtask

  // Behavioural synfifo read port: data and valid one cycle after the strobe.
  always @(posedge clk) begin
    #1;
    if (rd_pending && fifo_q.size() > 0) begin
      fifo_rd_data     = fifo_q.pop_front();
      fifo_rd_data_vld = 1'b1;
    end else begin
      fifo_rd_data     = inj_data;
      fifo_rd_data_vld = inject;
    end
    fifo_empty = (fifo_q.size() == 0);
  end

  // Monitor: words read but not yet delivered are lost on a flush.
  always @(negedge clk) begin
    logic [DATA_W-1:0] want;
    if (!rst_n) begin
      if (prev_stall) begin
        checkOutput("hold_valid", {31'd0, m_valid}, 32'd1);
        checkOutput("hold_data", {27'd0, m_data}, {27'd0, prev_data});
      end
      if (m_valid && m_ready) begin
        hs_count++;
        outstanding--;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_word: got %0d, expected none", m_data);
        end else begin
          want = exp_q.pop_front();
          checkOutput("stream_data", {27'd0, m_data}, {27'd0, want});
        end
      end
      if (flush) begin
        checkOutput("rd_in_flush", {31'd0, fifo_rd}, 32'd0);
        repeat (outstanding) if (exp_q.size() > 0) void'(exp_q.pop_front());
        outstanding = 0;
      end
      if (fifo_rd) begin
        rd_count++;
        outstanding++;
      end
      prev_stall = m_valid && !m_ready && !flush;
      prev_data  = m_data;
    end
    rd_pending = fifo_rd;
  end

  initial begin
    int r0;
    int h0;
    rst_n = 1'b1; en = 1'b0; flush = 1'b0; m_ready = 1'b0;
    fifo_empty = 1'b1; fifo_rd_data = '0; fifo_rd_data_vld = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    en = 1'b1; fifo_empty = 1'b0;
    #1;
    checkOutput("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
    checkOutput("rst_m_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("rst_m_data", {27'd0, m_data}, 32'd0);
    checkOutput("rst_xfer_cnt", {16'd0, xfer_cnt}, 32'd0);
    checkOutput("rst_err", {31'd0, err_unexp}, 32'd0);
    fifo_empty = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();

    $display("[TB] latency and order");
    m_ready = 1'b1;
    applyStimulus(5'd3); applyStimulus(5'd17); applyStimulus(5'd8);
    applyStimulus(5'd30); applyStimulus(5'd1);
    #1;
    checkOutput("lat_rd_t0", {31'd0, fifo_rd}, 32'd1);
    checkOutput("lat_valid_t0", {31'd0, m_valid}, 32'd0);
    tick();
    checkOutput("lat_valid_t1", {31'd0, m_valid}, 32'd0);
    tick();
    checkOutput("lat_valid_t2", {31'd0, m_valid}, 32'd1);
    checkOutput("lat_data_t2", {27'd0, m_data}, 32'd3);
    drain("latency");
    exp_xfer = 5;
    checkOutput("lat_xfer", {16'd0, xfer_cnt}, exp_xfer);

    $display("[TB] back-pressure");
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(DATA_W'(10 + i));
    r0 = rd_count;
    repeat (10) tick();
    checkOutput("bp_reads", rd_count - r0, 32'd3);
    checkOutput("bp_valid", {31'd0, m_valid}, 32'd1);
    checkOutput("bp_data", {27'd0, m_data}, 32'd10);
    h0 = hs_count;
    m_ready = 1'b1;
    repeat (8) tick();
    checkOutput("bp_no_gaps", hs_count - h0, 32'd8);
    drain("backpressure");
    exp_xfer += 8;
    checkOutput("bp_xfer", {16'd0, xfer_cnt}, exp_xfer);

    $display("[TB] flush with read in flight");
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(DATA_W'(20 + i));
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    checkOutput("flush_valid_next", {31'd0, m_valid}, 32'd0);
    m_ready = 1'b1;
    drain("flush");
    exp_xfer += 2;
    checkOutput("flush_xfer", {16'd0, xfer_cnt}, exp_xfer);

    $display("[TB] enable gating");
    en = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(DATA_W'(5 + i));
    r0 = rd_count;
    repeat (5) tick();
    checkOutput("en_no_reads", rd_count - r0, 32'd0);
    checkOutput("en_no_valid", {31'd0, m_valid}, 32'd0);
    en = 1'b1;
    #1;
    checkOutput("en_resume", {31'd0, fifo_rd}, 32'd1);
    tick();
    en = 1'b0;
    #1;
    checkOutput("en_drop_same_cycle", {31'd0, fifo_rd}, 32'd0);
    tick();
    en = 1'b1;
    drain("enable");
    exp_xfer += 4;
    checkOutput("en_xfer", {16'd0, xfer_cnt}, exp_xfer);

    $display("[TB] random soak");
    for (int c = 0; c < 2000; c++) begin
      lcg = lcg * 32'd1103515245 + 32'd12345;
      en      = (lcg[19:17] != 3'd0);
      m_ready = lcg[22] | lcg[23];
      if (lcg[25:24] != 2'd0 && fifo_q.size() < 8) begin
        applyStimulus(lcg[30:26]);
        exp_xfer++;
      end
      tick();
    end
    en = 1'b1;
    m_ready = 1'b1;
    drain("soak");
    checkOutput("soak_xfer", {16'd0, xfer_cnt}, exp_xfer & 32'hFFFF);
    checkOutput("soak_err", {31'd0, err_unexp}, 32'd0);

    $display("[TB] protocol error");
    en = 1'b0;
    tick();
    inject = 1'b1;
    inj_data = 5'd9;
    tick();
    inject = 1'b0;
    tick();
    checkOutput("err_set", {31'd0, err_unexp}, 32'd1);
    checkOutput("err_no_capture", {31'd0, m_valid}, 32'd0);
    repeat (5) tick();
    checkOutput("err_sticky", {31'd0, err_unexp}, 32'd1);
    checkOutput("err_xfer", {16'd0, xfer_cnt}, exp_xfer & 32'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
